// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Each 4-bit digit of bcd is meant to drive a BCD-to-Excess-3 encoder (digit MSB = a).
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_sh;
    logic [BW-1:0]     r_acc;
    logic [BW-1:0]     r_bcd;
    logic [CW-1:0]     r_cnt;
    logic [BW-1:0]     w_acc_adj;
    logic [BW-1:0]     w_acc_shift;
    logic              w_last;

    // Add 3 to every digit that is 5 or more, so the following doubling
    // carries correctly into the next decimal digit.
    function automatic logic [BW-1:0] adjust_digits(input logic [BW-1:0] a);
        logic [BW-1:0] r;
        r = a;
        for (int k = 0; k < DIGITS; k++) begin
            if (a[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = a[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign w_acc_adj   = adjust_digits(r_acc);
    // The operand MSB enters the LSB of the BCD scratch on each shift.
    assign w_acc_shift = {w_acc_adj[BW-2:0], r_sh[WIDTH-1]};
    assign w_last      = (r_cnt == LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; start is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture, shift/adjust datapath and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_bcd <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sh  <= bin;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_acc <= w_acc_shift;
                    r_sh  <= r_sh << 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_bcd <= w_acc_shift;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);
    assign bcd  = r_bcd;

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It sits directly upstream of the combinational BCD-to-Excess-3 encoder. Each 4-bit digit of `bcd` feeds one encoder instance as its a/b/c/d inputs, with a as the digit MSB. A start/busy/done handshake lets a controller convert one binary value at a time.

## Interface
- `WIDTH`, 8, binary input width in bits (≥ 1).
- `DIGITS`, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH − 1.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `start` input 1: conversion request; sampled only in IDLE.
- `bin` input WIDTH: binary operand; captured on the edge that accepts `start`.
- `busy` output 1: high while a conversion is in progress (SHIFT state).
- `done` output 1: one-cycle pulse; the result in `bcd` is new this cycle.
- `bcd` output 4*DIGITS: packed BCD result. Digit k occupies bits [4k+3:4k], with k=0 the ones digit. Held between conversions.

## Operation
- States: IDLE, SHIFT, DONE. Counter `cnt` is $clog2(WIDTH)+1 bits wide. Internal `sh` register holds the binary operand, WIDTH bits. Internal `acc` register holds the BCD scratch value, 4*DIGITS bits.
- **IDLE**, on `start`=1:
  - `sh` ← `bin`, `acc` ← 0, `cnt` ← 0.
  - Go to SHIFT.
  - If `start`=0, stay in IDLE.
- **SHIFT**, every cycle:
  - Adjust: each 4-bit digit of `acc` with value ≥ 5 gets +3. All digits are adjusted in parallel, combinationally.
  - Shift: {`acc`,`sh`} ← {adjusted `acc`, `sh`} << 1. The MSB of `sh` enters the LSB of `acc`.
  - `cnt` ← `cnt`+1.
  - When `cnt` == WIDTH−1 (the last shift), `bcd` ← the post-shift `acc` value and the state goes to DONE.
- **DONE**: `done`=1 for exactly one cycle, then unconditionally go to IDLE. `start` is ignored in DONE.
- `start` is ignored while in SHIFT. `bin` changing after capture has no effect.
- `bcd` changes only on the DONE-entry edge or on reset. Every digit is always in 0–9.
- `busy` = (state == SHIFT). `done` = (state == DONE). Both are decoded from registered state, so neither output is combinational from inputs.

## Timing
- Reset values, applied immediately when `rst` asserts: state=IDLE, `busy`=0, `done`=0, `bcd`=0. `sh`, `acc` and `cnt` are cleared to 0.
- Reset mid-conversion aborts it: no `done` pulse, `bcd` goes to 0. The first `start` after `rst` deasserts is accepted normally.
- Cycle timeline for `start` accepted at edge E0:
  - `busy` is high in cycles E0+1 … E0+WIDTH.
  - `done` is high in cycle E0+WIDTH+1, and `bcd` is valid from that cycle.
  - State is IDLE from E0+WIDTH+2.
- Latency from start-accept to `done` is WIDTH+1 cycles (9 for WIDTH=8).
- Minimum start-to-start spacing is WIDTH+2 cycles. Holding `start` high continuously yields one conversion every WIDTH+2 cycles, each using the `bin` value present on its accept edge.

## Test plan
- Reset: assert `rst` asynchronously between edges → `busy`=0, `done`=0 and `bcd`=12'h000 immediately, without waiting for an edge.
- Conversions, one per value with WIDTH=8, DIGITS=3:
  - `bin`=0 → `bcd`=12'h000.
  - `bin`=99 → `bcd`=12'h099.
  - `bin`=128 → `bcd`=12'h128.
  - `bin`=255 → `bcd`=12'h255.
  - For each: `done` occurs exactly 9 cycles after the accept edge, `busy` is high for exactly 8 cycles, and `done` lasts exactly 1 cycle.
- Ignored start: start `bin`=200, then pulse `start` with `bin`=7 at cycle 3 of SHIFT → a single `done` with `bcd`=12'h200, and no second conversion.
- Abort: start `bin`=255, assert `rst` at cycle 5 of SHIFT → no `done`, `bcd`=0. After release, start `bin`=42 → `bcd`=12'h042 after 9 cycles.
- Back-to-back: hold `start`=1 with `bin`=17 then 250 → `done` pulses 10 cycles apart with `bcd`=12'h017 then 12'h250. `bcd` holds 12'h017 until the second `done` cycle.
- Exhaustive sweep over `bin` 0–255 → every `bcd` equals the decimal value, every digit is ≤ 9, and each digit fed to the Excess-3 encoder gives digit+3.
